// File: rtl/dac_trigger_sequencer.sv
// dac_trigger_sequencer
// Issues synchronous trigger pulses to a bank of DAC channel controllers.
// A run fires a latched number of shots, either on a fixed cycle period
// (internal mode) or on rising edges of ext_trig separated by at least
// that period (external mode).
// Optional feature macro: DAC_TRIG_TIMESTAMP_EN adds ts_out/ts_valid, which
// stamp each shot with a free-running 64-bit cycle count.
module dac_trigger_sequencer #(
   parameter int NUM_CH = 8,
   parameter int PER_W  = 32,
   parameter int REP_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic [REP_W-1:0]  shot_count,
   input  logic [PER_W-1:0]  shot_period,
   input  logic              ext_mode,
   input  logic              ext_trig,
   output logic [NUM_CH-1:0] trigger_out,
   output logic              busy,
   output logic              done,
   output logic [REP_W-1:0]  shot_index
`ifdef DAC_TRIG_TIMESTAMP_EN
   ,
   output logic [63:0]       ts_out,
   output logic              ts_valid
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_FIRE,
      S_HOLDOFF
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [PER_W-1:0]  hold_cnt;
   logic [PER_W-1:0]  hold_cnt_nxt;
   logic              ext_q;
   logic              ext_edge;
   logic              accept_start;
   logic              hold_exit;
   logic              shots_left;
   logic              run_done;
   logic [NUM_CH-1:0] fire_mask;

   // Configuration captured when a run is accepted
   logic [NUM_CH-1:0] en_l;
   logic [REP_W-1:0]  count_l;
   logic [PER_W-1:0]  pm1_l;
   logic              ext_l;

   // A period of 0 behaves like 1; the holdoff counter stores P-1.
   function automatic logic [PER_W-1:0] period_m1(input logic [PER_W-1:0] p);
      return (p == '0) ? '0 : p - PER_W'(1);
   endfunction

   assign ext_edge     = ext_trig & ~ext_q;
   assign accept_start = (state == S_IDLE) & start & ~abort;
   assign shots_left   = (shot_index != count_l);
   assign hold_exit    = ((state == S_FIRE) && (pm1_l == '0)) ||
                         ((state == S_HOLDOFF) && (hold_cnt <= PER_W'(1)));
   // The first shot of an internal run fires before the latch is visible.
   assign fire_mask    = (state == S_IDLE) ? ch_enable : en_l;

   // Next-state decision; abort overrides everything, including completion.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      run_done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept_start) begin
               if (shot_count == '0) begin
                  run_done = 1'b1;
               end else if (ext_mode) begin
                  state_nxt = S_ARMED;
               end else begin
                  state_nxt = S_FIRE;
               end
            end
         end
         S_ARMED: begin
            if (ext_edge) state_nxt = S_FIRE;
         end
         S_FIRE: begin
            if (!hold_exit) begin
               state_nxt    = S_HOLDOFF;
               hold_cnt_nxt = pm1_l;
            end
         end
         S_HOLDOFF: begin
            if (!hold_exit) hold_cnt_nxt = hold_cnt - PER_W'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
      if (hold_exit) begin
         if (shots_left) begin
            state_nxt = ext_l ? S_ARMED : S_FIRE;
         end else begin
            state_nxt = S_IDLE;
            run_done  = 1'b1;
         end
      end
      if (abort) begin
         state_nxt = S_IDLE;
         run_done  = 1'b0;
      end
   end

   // Run configuration latch; only meaningful while a run is active.
   always_ff @(posedge clk) begin
      if (accept_start) begin
         en_l    <= ch_enable;
         count_l <= shot_count;
         pm1_l   <= period_m1(shot_period);
         ext_l   <= ext_mode;
      end
   end

   // Sequencer state and registered outputs, decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         hold_cnt    <= '0;
         ext_q       <= 1'b0;
         trigger_out <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         shot_index  <= '0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_cnt_nxt;
         ext_q       <= ext_trig;
         busy        <= (state_nxt != S_IDLE);
         done        <= run_done;
         trigger_out <= (state_nxt == S_FIRE) ? fire_mask : '0;
         if (accept_start) begin
            shot_index <= (state_nxt == S_FIRE) ? REP_W'(1) : '0;
         end else if (state_nxt == S_FIRE) begin
            shot_index <= shot_index + REP_W'(1);
         end
      end
   end

`ifdef DAC_TRIG_TIMESTAMP_EN
   logic [63:0] ts_cnt;

   // Free-running cycle counter, wraps modulo 2^64.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ts_cnt <= '0;
      else      ts_cnt <= ts_cnt + 64'd1;
   end

   // Stamp each shot with the counter value of its FIRE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_out   <= '0;
         ts_valid <= 1'b0;
      end else begin
         ts_valid <= (state_nxt == S_FIRE);
         if (state_nxt == S_FIRE) ts_out <= ts_cnt + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dac_trigger_sequencer.sv
// Scoreboard bench for dac_trigger_sequencer: the driver predicts trigger and
// done events from the shot timing rules and queues them; a negedge monitor
// pops and compares whenever the DUT presents a pulse.
`timescale 1ns/1ps
module tb_dac_trigger_sequencer;
   localparam int NUM_CH = 8;
   localparam int PER_W  = 32;
   localparam int REP_W  = 16;
   localparam int NEVER  = 1000000000;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [NUM_CH-1:0] ch_enable = '0;
   logic [REP_W-1:0]  shot_count = '0;
   logic [PER_W-1:0]  shot_period = '0;
   logic              ext_mode = 1'b0;
   logic              ext_trig = 1'b0;
   logic [NUM_CH-1:0] trigger_out;
   logic              busy;
   logic              done;
   logic [REP_W-1:0]  shot_index;
`ifdef DAC_TRIG_TIMESTAMP_EN
   logic [63:0]       ts_out;
   logic              ts_valid;
`endif

   dac_trigger_sequencer #(.NUM_CH(NUM_CH), .PER_W(PER_W), .REP_W(REP_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_enable(ch_enable),
      .shot_count(shot_count), .shot_period(shot_period), .ext_mode(ext_mode),
      .ext_trig(ext_trig), .trigger_out(trigger_out), .busy(busy), .done(done),
      .shot_index(shot_index)
`ifdef DAC_TRIG_TIMESTAMP_EN
      , .ts_out(ts_out), .ts_valid(ts_valid)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int                c;
      logic [NUM_CH-1:0] v;
   } trig_t;

   trig_t tq[$];     // expected visible trigger pulses
   int    dq[$];     // expected done pulses
   int    fires[$];  // every shot of the current run, visible or not
   int    run_start = 0;
   int    run_end   = 0;
   bit    ext_prev = 1'b0;
   bit    ext_cur  = 1'b0;
   bit    ext_active = 1'b0;
   int    ext_ready = 0;
   int    ext_left  = 0;
   int    ext_p     = 1;
   logic [NUM_CH-1:0] ext_en = '0;
   bit    have_ts = 1'b0;
   logic [63:0] last_ts = '0;
   int    last_ts_cyc = 0;

   // One clock step: drive ext_trig, scramble config, run the ext-mode model.
   task automatic tick_v(input logic v);
      trig_t e;
      @(posedge clk);
      #1;
      start       = 1'b0;
      abort       = 1'b0;
      ext_trig    = v;
      ch_enable   = NUM_CH'($urandom);
      shot_count  = REP_W'($urandom);
      shot_period = PER_W'($urandom);
      ext_mode    = 1'($urandom);
      ext_prev    = ext_cur;
      ext_cur     = v;
      if (ext_active && ext_cur && !ext_prev && cyc >= ext_ready && ext_left > 0) begin
         fires.push_back(cyc + 1);
         if (ext_en != '0) begin
            e.c = cyc + 1;
            e.v = ext_en;
            tq.push_back(e);
         end
         ext_ready = cyc + 1 + ext_p;
         ext_left--;
         if (ext_left == 0) begin
            dq.push_back(cyc + 1 + ext_p);
            run_end    = cyc + 1 + ext_p;
            ext_active = 1'b0;
         end
      end
   endtask

   task automatic tick();
      tick_v(($urandom_range(2) == 0) ? ~ext_cur : ext_cur);
   endtask

   task automatic begin_run(input bit mode, input int n, input int p,
                            input logic [NUM_CH-1:0] en, input logic xv);
      int    t;
      int    pe;
      trig_t e;
      tick_v(xv);
      t           = cyc;
      pe          = (p == 0) ? 1 : p;
      start       = 1'b1;
      ext_mode    = mode;
      shot_count  = REP_W'(n);
      shot_period = PER_W'(p);
      ch_enable   = en;
      fires.delete();
      run_start   = t;
      if (n == 0) begin
         dq.push_back(t + 1);
         run_end = t + 1;
      end else if (!mode) begin
         for (int k = 0; k < n; k++) begin
            fires.push_back(t + 1 + k * pe);
            if (en != '0) begin
               e.c = t + 1 + k * pe;
               e.v = en;
               tq.push_back(e);
            end
         end
         dq.push_back(t + 1 + n * pe);
         run_end = t + 1 + n * pe;
      end else begin
         ext_active = 1'b1;
         ext_ready  = t + 1;
         ext_left   = n;
         ext_p      = pe;
         ext_en     = en;
         run_end    = NEVER;
      end
   endtask

   task automatic abort_now();
      int a;
      a     = cyc;
      abort = 1'b1;
      while (tq.size() > 0 && tq[$].c > a) void'(tq.pop_back());
      while (dq.size() > 0 && dq[$] > a) void'(dq.pop_back());
      while (fires.size() > 0 && fires[$] > a) void'(fires.pop_back());
      run_end    = a + 1;
      ext_active = 1'b0;
   endtask

   // Step until the run is over, optionally aborting or re-starting it.
   task automatic run_body(input int abort_off, input int spur_off, input int budget);
      int w;
      w = 0;
      while (cyc < run_end + 2) begin
         tick();
         w++;
         if (w == budget && cyc < run_end) begin
            checks++;
            errors++;
            $display("FAIL run_timeout cyc=%0d got still_running required finished", cyc);
            abort_now();
         end else begin
            if (w == abort_off && cyc < run_end) abort_now();
            if (w == spur_off && cyc > run_start && cyc < run_end) start = 1'b1;
         end
      end
      checks++;
      if (tq.size() != 0 || dq.size() != 0) begin
         errors++;
         $display("FAIL pending_events got trig=%0d done=%0d required 0 0", tq.size(), dq.size());
      end
      checks++;
      if (shot_index !== REP_W'(fires.size())) begin
         errors++;
         $display("FAIL shot_index got %0d required %0d", shot_index, fires.size());
      end
      tq.delete();
      dq.delete();
   endtask

   task automatic check_zero(input string name, input logic [31:0] got);
      checks++;
      if (got !== 32'd0) begin
         errors++;
         $display("FAIL %s got %0h required 0", name, got);
      end
   endtask

   // Monitor: compare every presented pulse against the scoreboard.
   always @(negedge clk) begin : mon
      trig_t e;
      bit    eb;
      if (rst) begin
         eb = (cyc > run_start) && (cyc < run_end);
         checks++;
         if (busy !== eb) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, eb);
         end
         while (tq.size() > 0 && tq[0].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL trig_missing cyc=%0d got none required %h", tq[0].c, tq[0].v);
            void'(tq.pop_front());
         end
         while (dq.size() > 0 && dq[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL done_missing cyc=%0d got none required pulse", dq[0]);
            void'(dq.pop_front());
         end
         if (trigger_out !== '0) begin
            checks++;
            if (tq.size() == 0) begin
               errors++;
               $display("FAIL trig_unexpected cyc=%0d got %h required 00", cyc, trigger_out);
            end else begin
               e = tq.pop_front();
               if (e.c != cyc || e.v !== trigger_out) begin
                  errors++;
                  $display("FAIL trig cyc=%0d got %h required %h at cyc %0d", cyc, trigger_out, e.v, e.c);
               end
            end
`ifdef DAC_TRIG_TIMESTAMP_EN
            checks++;
            if (ts_valid !== 1'b1) begin
               errors++;
               $display("FAIL ts_valid cyc=%0d got %b required 1", cyc, ts_valid);
            end
`endif
         end
         if (done !== 1'b0) begin
            checks++;
            if (dq.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected cyc=%0d got %b required 0", cyc, done);
            end else begin
               if (dq[0] != cyc || done !== 1'b1) begin
                  errors++;
                  $display("FAIL done cyc=%0d got %b required pulse at cyc %0d", cyc, done, dq[0]);
               end
               void'(dq.pop_front());
            end
         end
`ifdef DAC_TRIG_TIMESTAMP_EN
         if (ts_valid === 1'b1) begin
            if (have_ts) begin
               checks++;
               if (ts_out - last_ts != 64'(cyc - last_ts_cyc)) begin
                  errors++;
                  $display("FAIL ts_delta cyc=%0d got %0d required %0d", cyc, ts_out - last_ts, cyc - last_ts_cyc);
               end
            end
            have_ts     = 1'b1;
            last_ts     = ts_out;
            last_ts_cyc = cyc;
         end
`endif
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog got no_finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int p;
      int ab;
      int sp;
      logic [NUM_CH-1:0] en;
      bit md;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      check_zero("reset_trigger_out", 32'(trigger_out));
      check_zero("reset_busy", 32'(busy));
      check_zero("reset_done", 32'(done));
      check_zero("reset_shot_index", 32'(shot_index));
      repeat (2) tick();

      // Internal run A5 x3 every 10 cycles
      begin_run(1'b0, 3, 10, 8'hA5, 1'b0);
      run_body(0, 0, 200);
      // Zero shots; zero period
      begin_run(1'b0, 0, 7, 8'hFF, 1'b0);
      run_body(0, 0, 50);
      begin_run(1'b0, 4, 0, 8'h5A, 1'b0);
      run_body(0, 0, 50);
      // No enabled channels still counts shots
      begin_run(1'b0, 3, 2, 8'h00, 1'b0);
      run_body(0, 0, 50);

      // External mode: edges at e0, e0+2 (in holdoff), e0+9
      begin_run(1'b1, 2, 5, 8'h3C, 1'b0);
      repeat (3) tick_v(1'b0);
      tick_v(1'b1);
      tick_v(1'b0);
      tick_v(1'b1);
      repeat (6) tick_v(1'b0);
      tick_v(1'b1);
      tick_v(1'b0);
      run_body(0, 0, 200);

      // Abort in holdoff of shot 2 of 5, with an ignored restart before it
      begin_run(1'b0, 5, 6, 8'hFF, 1'b0);
      run_body(8, 3, 200);

      // start and abort together in IDLE: no run
      tick();
      start = 1'b1;
      abort = 1'b1;
      repeat (6) tick();

      // Async reset in the middle of a run
      begin_run(1'b0, 5, 8, 8'hFF, 1'b0);
      repeat (12) tick();
      #2;
      rst      = 1'b0;
      ext_trig = 1'b0;
      #1;
      check_zero("midrun_trigger_out", 32'(trigger_out));
      check_zero("midrun_busy", 32'(busy));
      check_zero("midrun_done", 32'(done));
      check_zero("midrun_shot_index", 32'(shot_index));
      tq.delete();
      dq.delete();
      fires.delete();
      ext_active = 1'b0;
      ext_cur    = 1'b0;
      run_end    = cyc;
      have_ts    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (8) tick();

      // Randomized runs
      repeat (40) begin
         md = 1'($urandom);
         n  = $urandom_range(5);
         case ($urandom_range(3))
            0:       p = 0;
            1:       p = 1;
            2:       p = 2;
            default: p = $urandom_range(3, 12);
         endcase
         en = ($urandom_range(7) == 0) ? '0 : NUM_CH'($urandom);
         ab = ($urandom_range(3) == 0) ? $urandom_range(1, 40) : 0;
         sp = ($urandom_range(2) == 0) ? $urandom_range(1, 30) : 0;
         begin_run(md, n, p, en, ($urandom_range(2) == 0) ? ~ext_cur : ext_cur);
         run_body(ab, sp, 1500);
         repeat ($urandom_range(3)) tick();
      end

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
